// File: rtl/alu_operand_stage.sv
// ALU operand select with built-in EX/MEM and MEM/WB forwarding, registered into ID/EX.
// Optional forwarding-event counter is enabled by ALU_OPERAND_FWD_STATS_EN.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              ALUScr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] constante,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] store_data,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef ALU_OPERAND_FWD_STATS_EN
    ,
    output logic [15:0]       fwd_count
`endif
);

    logic              ex_a, mw_a, ex_b, mw_b;
    logic [1:0]        sel_a_n, sel_b_n;
    logic [DATA_W-1:0] a_n, rt_n, b_n;

    // EX/MEM holds the newer result, so it masks a MEM/WB match
    assign ex_a = exmem_regwrite && (exmem_rd == rs_addr) && (rs_addr != '0);
    assign mw_a = memwb_regwrite && (memwb_rd == rs_addr) && (rs_addr != '0) && !ex_a;
    assign ex_b = exmem_regwrite && (exmem_rd == rt_addr) && (rt_addr != '0);
    assign mw_b = memwb_regwrite && (memwb_rd == rt_addr) && (rt_addr != '0) && !ex_b;

    always_comb begin
        sel_a_n = 2'd0;
        a_n     = rs_data;
        unique case (1'b1)
            ex_a: begin
                sel_a_n = 2'd1;
                a_n     = exmem_data;
            end
            mw_a: begin
                sel_a_n = 2'd2;
                a_n     = memwb_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_b_n = 2'd0;
        rt_n    = rt_data;
        unique case (1'b1)
            ex_b: begin
                sel_b_n = 2'd1;
                rt_n    = exmem_data;
            end
            mw_b: begin
                sel_b_n = 2'd2;
                rt_n    = memwb_data;
            end
            default: ;
        endcase
    end

    assign b_n = ALUScr ? constante : rt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
            fwd_a_sel  <= 2'd0;
            fwd_b_sel  <= 2'd0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
            fwd_a_sel  <= 2'd0;
            fwd_b_sel  <= 2'd0;
        end else if (!stall) begin
            out_valid <= in_valid;
            if (in_valid) begin
                op_a       <= a_n;
                op_b       <= b_n;
                store_data <= rt_n;
                fwd_a_sel  <= sel_a_n;
                fwd_b_sel  <= sel_b_n;
            end
        end
    end

`ifdef ALU_OPERAND_FWD_STATS_EN
    logic hit;
    assign hit = in_valid && !stall && !flush
               && ((sel_a_n != 2'd0) || (sel_b_n != 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count <= 16'd0;
        end else if (hit && (fwd_count != 16'hFFFF)) begin
            fwd_count <= fwd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: reference model plus directed literals.
// Counter checks are active when ALU_OPERAND_FWD_STATS_EN is defined.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, ALUScr;
    logic [4:0]  rs_addr, rt_addr, exmem_rd, memwb_rd;
    logic [31:0] rs_data, rt_data, constante, exmem_data, memwb_data;
    logic        exmem_regwrite, memwb_regwrite;
    logic        out_valid;
    logic [31:0] op_a, op_b, store_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef ALU_OPERAND_FWD_STATS_EN
    logic [15:0] fwd_count;
`endif

    int passes = 0;
    int total  = 0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .flush(flush), .ALUScr(ALUScr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .constante(constante),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_data(exmem_data), .memwb_regwrite(memwb_regwrite),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data), .out_valid(out_valid),
        .op_a(op_a), .op_b(op_b), .store_data(store_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef ALU_OPERAND_FWD_STATS_EN
        , .fwd_count(fwd_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // reference model: source code for one register address
    function automatic int src(input logic [4:0] a);
        if (a == 0) return 0;
        if (exmem_regwrite && exmem_rd == a) return 1;
        if (memwb_regwrite && memwb_rd == a) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] val(input int code, input logic [31:0] rf);
        if (code == 1) return exmem_data;
        if (code == 2) return memwb_data;
        return rf;
    endfunction

    logic        m_valid;
    logic [31:0] m_a, m_b, m_st;
    int          m_sa, m_sb, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        int sa, sb;
        if (!rst_n) begin
            m_valid <= 0; m_a <= 0; m_b <= 0; m_st <= 0;
            m_sa <= 0; m_sb <= 0; m_cnt <= 0;
        end else begin
            sa = src(rs_addr);
            sb = src(rt_addr);
            if (flush) begin
                m_valid <= 0; m_a <= 0; m_b <= 0; m_st <= 0;
                m_sa <= 0; m_sb <= 0;
            end else if (!stall) begin
                m_valid <= in_valid;
                if (in_valid) begin
                    m_a  <= val(sa, rs_data);
                    m_st <= val(sb, rt_data);
                    m_b  <= ALUScr ? constante : val(sb, rt_data);
                    m_sa <= sa;
                    m_sb <= sb;
                    if ((sa != 0 || sb != 0) && m_cnt < 65535) m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("m_op_a", op_a, m_a);
        chk("m_op_b", op_b, m_b);
        chk("m_store", store_data, m_st);
        chk("m_sel_a", {30'd0, fwd_a_sel}, 32'(m_sa));
        chk("m_sel_b", {30'd0, fwd_b_sel}, 32'(m_sb));
`ifdef ALU_OPERAND_FWD_STATS_EN
        chk("m_count", {16'd0, fwd_count}, 32'(m_cnt));
`endif
    end

    task automatic clr();
        in_valid = 0; stall = 0; flush = 0; ALUScr = 0;
        rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0; constante = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_data = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        clr();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);

        in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 5; rt_data = 7;
        tick();
        chk("basic_a", op_a, 32'd5);
        chk("basic_b", op_b, 32'd7);
        chk("basic_st", store_data, 32'd7);
        chk("basic_sels", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);

        clr(); in_valid = 1; rs_addr = 8; rs_data = 32'h11;
        exmem_regwrite = 1; exmem_rd = 8; exmem_data = 32'hAAAA;
        memwb_regwrite = 1; memwb_rd = 8; memwb_data = 32'hBBBB;
        tick();
        chk("prio_a", op_a, 32'hAAAA);
        chk("prio_sel_a", {30'd0, fwd_a_sel}, 32'd1);

        clr(); in_valid = 1; rt_addr = 9; rt_data = 32'h22; ALUScr = 1;
        memwb_regwrite = 1; memwb_rd = 9; memwb_data = 32'h1234;
        constante = 32'hFFFFFFFC;
        tick();
        chk("imm_b", op_b, 32'hFFFFFFFC);
        chk("imm_st", store_data, 32'h1234);
        chk("imm_sel_b", {30'd0, fwd_b_sel}, 32'd2);

        clr(); in_valid = 1; rs_addr = 0; rs_data = 0;
        exmem_regwrite = 1; exmem_rd = 0; exmem_data = 32'hDEAD;
        tick();
        chk("zero_a", op_a, 32'd0);
        chk("zero_sel_a", {30'd0, fwd_a_sel}, 32'd0);

        clr(); in_valid = 1; rs_addr = 3; rs_data = 3;
        tick();
        chk("load3", op_a, 32'd3);
        for (int i = 0; i < 3; i++) begin
            stall = 1; in_valid = i[0]; rs_data = 32'h100 + i;
            exmem_regwrite = 1; exmem_rd = 3; exmem_data = 32'h900 + i;
            tick();
            chk("stall_a", op_a, 32'd3);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        stall = 1; flush = 1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_a", op_a, 32'd0);

        clr(); in_valid = 1; rs_addr = 4; rs_data = 32'h44; rt_data = 32'h55;
        tick();
        in_valid = 0; rs_data = 32'h99;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_hold_a", op_a, 32'h44);

        for (int i = 0; i < 40; i++) begin
            in_valid = ($urandom % 4) != 0;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 7) == 0;
            ALUScr = $urandom % 2;
            rs_addr = 5'($urandom % 4); rt_addr = 5'($urandom % 4);
            rs_data = $urandom; rt_data = $urandom; constante = $urandom;
            exmem_regwrite = $urandom % 2; exmem_rd = 5'($urandom % 4);
            exmem_data = $urandom;
            memwb_regwrite = $urandom % 2; memwb_rd = 5'($urandom % 4);
            memwb_data = $urandom;
            tick();
        end

        clr(); in_valid = 1; rs_addr = 6; rs_data = 32'h77;
        tick();
        clr();
        #1 rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_a", op_a, 32'd0);
`ifdef ALU_OPERAND_FWD_STATS_EN
        chk("arst_count", {16'd0, fwd_count}, 32'd0);
`endif
        #1 rst_n = 1;

        tick();
        in_valid = 1; rs_addr = 1; exmem_regwrite = 1; exmem_rd = 1;
        exmem_data = 32'h10;
        tick();
        clr(); in_valid = 1; rt_addr = 2; memwb_regwrite = 1; memwb_rd = 2;
        memwb_data = 32'h20;
        tick();
        clr(); in_valid = 1; rs_addr = 5; rs_data = 32'h30;
        tick();
        clr(); in_valid = 1; rs_addr = 7; memwb_regwrite = 1; memwb_rd = 7;
        memwb_data = 32'h40;
        tick();
        chk("acc4_a", op_a, 32'h40);
        clr(); in_valid = 1; flush = 1; rs_addr = 1; exmem_regwrite = 1;
        exmem_rd = 1; exmem_data = 32'h50;
        tick();
        chk("flush_cap_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_OPERAND_FWD_STATS_EN
        chk("stat_count", {16'd0, fwd_count}, 32'd3);
`endif
        clr();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
